// File: rtl/bta8_operand_loader.sv
// Purpose: gathers up to 8 operands from a stream and presents them in parallel to the tree adder, then registers the sum.
// Latency: the sum is captured ADD_LAT cycles after the final operand is accepted, and res_valid rises on that edge.
// Backpressure: in_ready is low from the end of a batch until the result handshakes; the result holds while res_ready is low.
module bta8_operand_loader #(
  parameter int N       = 8,
  parameter int M       = 16,
  parameter int ADD_LAT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [M-1:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic [M-1:0] A,
  output logic [M-1:0] B,
  output logic [M-1:0] C,
  output logic [M-1:0] D,
  output logic [M-1:0] E,
  output logic [M-1:0] F,
  output logic [M-1:0] G,
  output logic [M-1:0] H,
  output logic         C0,
  input  logic [M+2:0] add_sum,
  input  logic         add_carry,
  output logic         res_valid,
  output logic [M+2:0] res_data,
  output logic         res_carry,
  input  logic         res_ready,
  output logic [3:0]   res_count
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {S_FILL, S_HOLD, S_OUT} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N-1:0][M-1:0] slot_q, slot_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [CW-1:0]       wait_q, wait_d;
  logic                res_valid_q, res_valid_d;
  logic [M+2:0]        res_data_q, res_data_d;
  logic                res_carry_q, res_carry_d;
  logic [3:0]          res_count_q, res_count_d;

  // Next-state logic: fill slots, wait out the adder latency, then hold the result until drained.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_count_d = res_count_q;
    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          slot_d[idx_q] = in_data;
          idx_d         = idx_q + 1'b1;
          if (idx_q == IW'(N - 1) || in_last) begin
            // Slots above the last one are normally already zero; clearing them here keeps that guaranteed.
            for (int i = 0; i < N; i++) begin
              if (i > int'(idx_q)) slot_d[i] = '0;
            end
            cnt_d   = 4'(idx_q) + 4'd1;
            wait_d  = CW'(ADD_LAT);
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == CW'(1)) begin
          res_data_d  = add_sum;
          res_carry_d = add_carry;
          res_valid_d = 1'b1;
          res_count_d = cnt_q;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          idx_d       = '0;
          slot_d      = '0;
          state_d     = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // State and datapath registers; reset discards any batch or result in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      idx_q       <= '0;
      slot_q      <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_count_q <= res_count_d;
    end
  end

  assign in_ready  = (state_q == S_FILL);
  assign C0        = 1'b0;
  assign A         = slot_q[0];
  assign B         = slot_q[1];
  assign C         = slot_q[2];
  assign D         = slot_q[3];
  assign E         = slot_q[4];
  assign F         = slot_q[5];
  assign G         = slot_q[6];
  assign H         = slot_q[7];
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign res_count = res_count_q;

endmodule

// File: tb/tb_bta8_operand_loader.sv
module tb_bta8_operand_loader;

  localparam int ADD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic [15:0] A, B, C, D, E, F, G, H;
  logic        C0;
  logic [18:0] add_sum;
  logic        add_carry;
  logic        res_valid;
  logic [18:0] res_data;
  logic        res_carry;
  logic        res_ready;
  logic [3:0]  res_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bta8_operand_loader #(.N(8), .M(16), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H), .C0(C0),
    .add_sum(add_sum), .add_carry(add_carry),
    .res_valid(res_valid), .res_data(res_data), .res_carry(res_carry),
    .res_ready(res_ready), .res_count(res_count)
  );

  // Tree adder model: the sum of the current operands reaches add_sum after two register
  // stages, so it is valid at the capture edge only if the operands were stable for ADD_LAT cycles.
  wire [7:0][15:0] ops = {H, G, F, E, D, C, B, A};
  wire [18:0] sum_now = 19'(A) + 19'(B) + 19'(C) + 19'(D) + 19'(E) + 19'(F) + 19'(G) + 19'(H);
  logic [18:0] pipe0 = '0, pipe1 = '0;
  always @(posedge clk) begin
    pipe0 <= sum_now;
    pipe1 <= pipe0;
  end
  assign add_sum   = pipe1;
  assign add_carry = 1'b0;

  typedef struct {
    string           name;
    int              n;
    logic            use_last;
    logic [7:0][15:0] d;
    logic [18:0]     sum;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand and hold it until it is accepted (bounded).
  task automatic push(input logic [15:0] d, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (!in_ready) chk("push_timeout", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait (bounded) for res_valid; returns the number of cycles waited.
  task automatic wait_res(output int k);
    k = 0;
    while (!res_valid && k < 40) begin
      step();
      k++;
    end
  endtask

  // Run one batch with res_ready high and check operands, latency, result and drain.
  task automatic run_batch(input vec_t v);
    logic [7:0][15:0] exp_ops;
    int k;
    for (int i = 0; i < 8; i++) exp_ops[i] = (i < v.n) ? v.d[i] : 16'd0;
    for (int i = 0; i < v.n; i++) push(v.d[i], v.use_last && (i == v.n - 1));
    chk({v.name, "_ops"}, 128'(ops), 128'(exp_ops));
    chk({v.name, "_hold_rdy"}, 128'(in_ready), 128'(0));
    wait_res(k);
    chk({v.name, "_lat"}, 128'(k), 128'(ADD_LAT));
    chk({v.name, "_data"}, 128'(res_data), 128'(v.sum));
    chk({v.name, "_count"}, 128'(res_count), 128'(v.n));
    chk({v.name, "_carry"}, 128'(res_carry), 128'(0));
    step();
    chk({v.name, "_drain_vld"}, 128'(res_valid), 128'(0));
    chk({v.name, "_drain_rdy"}, 128'(in_ready), 128'(1));
    chk({v.name, "_drain_ops"}, 128'(ops), 128'(0));
  endtask

  initial begin
    int k;
    logic seen;
    vec_t v;

    vecs[0].name = "full";  vecs[0].n = 8; vecs[0].use_last = 1'b0;
    vecs[0].d = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}; vecs[0].sum = 19'd36;
    vecs[1].name = "max";   vecs[1].n = 8; vecs[1].use_last = 1'b0;
    vecs[1].d = {8{16'hFFFF}}; vecs[1].sum = 19'h7FFF8;
    vecs[2].name = "short"; vecs[2].n = 3; vecs[2].use_last = 1'b1;
    vecs[2].d = {80'd0, 16'd300, 16'd200, 16'd100}; vecs[2].sum = 19'd600;
    vecs[3].name = "last8"; vecs[3].n = 8; vecs[3].use_last = 1'b1;
    vecs[3].d = {16'd80, 16'd70, 16'd60, 16'd50, 16'd40, 16'd30, 16'd20, 16'd10}; vecs[3].sum = 19'd360;
    vecs[4].name = "single"; vecs[4].n = 1; vecs[4].use_last = 1'b1;
    vecs[4].d = {112'd0, 16'd7}; vecs[4].sum = 19'd7;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b1;
    step();
    step();
    chk("rst_ops", 128'(ops), 128'(0));
    chk("rst_res_valid", 128'(res_valid), 128'(0));
    chk("rst_res_data", 128'(res_data), 128'(0));
    chk("rst_res_count", 128'(res_count), 128'(0));
    chk("rst_res_carry", 128'(res_carry), 128'(0));
    chk("rst_c0", 128'(C0), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    for (int i = 0; i < 5; i++) run_batch(vecs[i]);

    // Backpressure: result held 10 cycles while in_valid pulses are ignored.
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(16'd3, 1'b0);
    wait_res(k);
    chk("bp_lat", 128'(k), 128'(ADD_LAT));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = 16'hDEAD;
      step();
      chk("bp_vld", 128'(res_valid), 128'(1));
      chk("bp_data", 128'(res_data), 128'(24));
      chk("bp_rdy", 128'(in_ready), 128'(0));
      chk("bp_ops", 128'(ops), 128'({8{16'd3}}));
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    step();
    chk("bp_rel_rdy", 128'(in_ready), 128'(1));
    chk("bp_rel_vld", 128'(res_valid), 128'(0));
    chk("bp_rel_ops", 128'(ops), 128'(0));
    v.name = "bp_next"; v.n = 1; v.use_last = 1'b1; v.d = {112'd0, 16'd9}; v.sum = 19'd9;
    run_batch(v);

    // Input bubbles: valid on alternate cycles, junk data on the idle ones.
    for (int i = 0; i < 16; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = (i % 2 == 0) ? 16'd5 : 16'h1000;
      step();
    end
    in_valid = 1'b0;
    chk("bub_ops", 128'(ops), 128'({8{16'd5}}));
    wait_res(k);
    chk("bub_data", 128'(res_data), 128'(40));
    chk("bub_count", 128'(res_count), 128'(8));
    step();
    chk("bub_drain", 128'(in_ready), 128'(1));

    // Reset mid-fill, then again during HOLD.
    for (int i = 0; i < 4; i++) push(16'd9, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rstfill_ops", 128'(ops), 128'(0));
    chk("rstfill_vld", 128'(res_valid), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 8; i++) push(16'd2, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    chk("rsthold_ops", 128'(ops), 128'(0));
    chk("rsthold_vld", 128'(res_valid), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < ADD_LAT + 4; i++) begin
      step();
      if (res_valid) seen = 1'b1;
    end
    chk("rsthold_no_result", 128'(seen), 128'(0));
    chk("rsthold_rdy", 128'(in_ready), 128'(1));
    v.name = "ones"; v.n = 8; v.use_last = 1'b0; v.d = {8{16'd1}}; v.sum = 19'd8;
    run_batch(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bta8_operand_loader.md
Name: bta8_operand_loader

Overview:
- Front-end stage for the 8-operand, 16-bit binary tree adder.
- Collects operands one per cycle over a valid/ready stream into an 8-slot register bank, then presents all eight in parallel on the adder's A..H inputs.
- Holds the operands stable for the adder's pipeline latency, then captures the 19-bit tree sum into a result register with its own valid/ready handshake.
- Supports short batches (in_last); unused slots are zero-filled.

Parameters:
- N, 8, number of operands per batch (slot count; fixed at 8 for this tree).
- M, 16, operand width in bits.
- ADD_LAT, 3, clock cycles from operands stable at the adder inputs to a valid sum at the adder output; must be ≥ 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream operand valid.
- in_data  input  M  operand value.
- in_last  input  1  marks the final operand of a short batch; qualified by in_valid.
- in_ready  output  1  loader can accept an operand.
- A, B, C, D, E, F, G, H  output  M each  parallel operands to the tree adder; slot 0 is A, slot 7 is H.
- C0  output  1  carry-in to the tree adder; tied to 0.
- add_sum  input  M+3  sum from the tree adder.
- add_carry  input  1  carry from the tree adder.
- res_valid  output  1  result register holds an unconsumed result.
- res_data  output  M+3  captured sum.
- res_carry  output  1  captured carry; always 0 for legal input ranges.
- res_ready  input  1  downstream accepts the result.
- res_count  output  4  number of operands in the captured batch, 1..8.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State is FILL.
  - Slot index is 0.
  - A..H are 0.
  - res_valid, res_data, res_carry and res_count are 0.
  - Wait counter is 0.
  - in_ready is 1 after reset deasserts.
- Reset mid-operation: reset asserted in any state discards the batch and the result immediately. No partial result is ever emitted.
- Accept: an operand transfers only on a clk edge where in_valid && in_ready.
- FILL state:
  - in_ready = 1.
  - Each accept writes in_data to slot[idx], then idx increments.
  - Accept with idx == 7, or with in_last = 1: zero all slots above idx in the same edge, record count = idx+1, load the wait counter with ADD_LAT, and go to HOLD.
  - Otherwise stay in FILL.
- HOLD state:
  - in_ready = 0.
  - A..H do not change.
  - The wait counter decrements each cycle.
  - When the counter reaches 1: on that edge, capture add_sum → res_data and add_carry → res_carry, set res_valid = 1 and res_count = count, and go to OUT.
  - Operands are therefore stable for exactly ADD_LAT cycles before capture.
- OUT state:
  - in_ready = 0.
  - res_valid stays 1, and res_data, res_carry and res_count hold, until res_ready = 1.
  - On the edge where res_valid && res_ready: clear res_valid, reset idx to 0, clear all slots to 0, and go to FILL.
  - in_ready rises the cycle after the handshake. There is no overlap between result drain and the next fill.
- A..H must not glitch or change while in HOLD or OUT.
- Slots written during FILL are visible on A..H immediately. The adder output is ignored until HOLD completes.
- in_last on the 8th operand is equivalent to a full batch (count = 8).
- in_valid while in_ready = 0 is ignored; data is not consumed.
- Width rule: the maximum sum is 8 × (2^M − 1), which fits in M+3 bits. res_carry is captured as-is and is not interpreted.
- Throughput: a full batch takes 8 + ADD_LAT + 1 cycles minimum, assuming res_ready is held high.

Test Plan:
- Full batch: operands 1,2,...,8 back-to-back, res_ready = 1.
  - A..H = 1..8.
  - res_valid rises exactly ADD_LAT cycles after the 8th accept; res_data = 36, res_count = 8, res_carry = 0.
- Max values: eight operands of 16'hFFFF.
  - res_data = 19'h7FFF8 (524280), res_carry = 0.
- Short batch: operands 100, 200, 300, with in_last on the 3rd.
  - D..H = 0; res_data = 600, res_count = 3.
- Backpressure: res_ready = 0 for 10 cycles after res_valid rises.
  - res_valid, res_data and A..H are held; in_ready = 0 throughout; in_valid pulses are not consumed.
  - After res_ready = 1, in_ready = 1 on the next cycle with idx = 0.
- Input bubbles: in_valid toggling 1,0,1,0 across 8 operands of 5.
  - Only the valid cycles are accepted; res_data = 40.
- Reset mid-batch: assert rst_n = 0 after 4 accepts, then again during HOLD.
  - All outputs go to 0 immediately; no res_valid appears.
  - The next full batch of 1s gives res_data = 8.
